imem_loader: RTL

- Writer side of the byte-addressed instruction memory: loads a program into the 512 x 8 instruction store before the CPU fetches from it.
- Accepts 32-bit instruction words on a valid/ready stream and serializes each into four big-endian byte writes: MSB at address A, LSB at A+3.
- Sits between the boot/test-bench program source and the memory's write port. Fetch is unaffected; the loader is only active while the core is held off.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_word_serializer.sv | 45 ++++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader slice.
//   IMEM_ADDR_W    byte address width of the instruction store
//   IMEM_BYTES     number of bytes in the store
//   BYTES_PER_WORD bytes per instruction word
//   BYTE_IDX_W     width of the byte index within a word
//   loader_state_t loader FSM states
package imem_pkg;

    localparam int IMEM_ADDR_W    = 9;
    localparam int IMEM_BYTES     = 2 ** IMEM_ADDR_W;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        WRITE     = 3'd2,
        DONE      = 3'd3,
        ERR       = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_word_serializer.sv
// imem_word_serializer: holds one instruction word and presents it one byte
// at a time, most significant byte first.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture load_word and restart at byte index 0
//   advance     step to the next byte (ignored when load is high)
//   load_word   word to serialize
//   byte_out    current byte, taken straight from the top of the holding register
//   byte_idx    index of the byte currently on byte_out (0 = MSB)
module imem_word_serializer
    import imem_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_W-1:0]     load_word,
    output logic [7:0]            byte_out,
    output logic [BYTE_IDX_W-1:0] byte_idx
);

    logic [WORD_W-1:0]     hold_q;
    logic [BYTE_IDX_W-1:0] idx_q;

    // Shifting left keeps the current byte in the top 8 bits, so byte_out is
    // a plain register slice with no output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            hold_q <= load_word;
            idx_q  <= '0;
        end else if (advance) begin
            hold_q <= {hold_q[WORD_W-9:0], 8'h00};
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign byte_out = hold_q[WORD_W-1 -: 8];
    assign byte_idx = idx_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the byte-addressed instruction memory. Takes
// 32-bit words on a valid/ready stream and writes each as four big-endian
// bytes (MSB at A, LSB at A+3) starting at a word-aligned base address.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a 32-bit running sum
// of accepted words on the checksum output.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         one-cycle pulse, honoured only in IDLE, DONE or ERR
//   base_addr     first byte address (low two bits ignored)
//   word_count    number of words to load (0 allowed)
//   in_valid/in_ready/in_data  input word stream
//   mem_we/mem_addr/mem_wdata  byte write port of the instruction store
//   busy          load in progress
//   done, err     sticky completion / range-overflow flags, cleared by start
//   words_loaded  words fully written in the current load
//   checksum      (IMEM_LOADER_CHECKSUM_EN only) sum of accepted words mod 2**32
//   dbg_state     current FSM state
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   word_count,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   words_loaded,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]        checksum,
`endif
    output loader_state_t      dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready is registered and high only in WAIT_WORD; in_valid in any other
    // state leaves the word with the source. in_valid may drop at will.

    localparam int SUM_W = ADDR_W + 3;
    localparam logic [SUM_W-1:0] MEM_SIZE = SUM_W'(2 ** ADDR_W);

    loader_state_t state_q, state_d;

    logic [ADDR_W-1:0]     addr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      loaded_q;
    logic [ADDR_W-1:0]     base_aligned;
    logic [SUM_W-1:0]      range_end;
    logic                  range_bad;
    logic                  start_ok;
    logic                  accept;
    logic                  writing;
    logic                  last_byte;
    logic                  last_word;
    logic [7:0]            ser_byte;
    logic [BYTE_IDX_W-1:0] byte_idx;

    assign base_aligned = base_addr & ~ADDR_W'(3);
    // Three spare bits hold the worst case base + 4*count without wrapping.
    assign range_end    = SUM_W'(base_aligned) + SUM_W'({word_count, 2'b00});
    assign range_bad    = range_end > MEM_SIZE;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign accept    = (state_q == WAIT_WORD) && in_valid && in_ready;
    assign writing   = (state_q == WRITE);
    assign last_byte = writing && (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign last_word = last_byte && (loaded_q + CNT_W'(1) == count_q);

    imem_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (writing),
        .load_word (in_data),
        .byte_out  (ser_byte),
        .byte_idx  (byte_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (range_bad) begin
                        state_d = ERR;
                    end else if (word_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_WORD;
                    end
                end
            end
            WAIT_WORD: begin
                if (accept) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else if (last_byte) begin
                    state_d = WAIT_WORD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            loaded_q <= '0;
        end else begin
            in_ready <= (state_d == WAIT_WORD);
            mem_we   <= (state_d == WRITE);
            busy     <= (state_d == WAIT_WORD) || (state_d == WRITE);
            done     <= (state_d == DONE);
            err      <= (state_d == ERR);
            if (start_ok) begin
                addr_q   <= base_aligned;
                count_q  <= word_count;
                loaded_q <= '0;
            end else if (writing) begin
                // The range check at start keeps this from wrapping while
                // bytes are still being written.
                addr_q <= addr_q + 1'b1;
                if (last_byte) begin
                    loaded_q <= loaded_q + 1'b1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + in_data;
        end
    end
`endif

    assign mem_addr     = addr_q;
    assign mem_wdata    = ser_byte;
    assign words_loaded = loaded_q;
    assign dbg_state    = state_q;

endmodule
